// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM device model: command decode, init states, error bit and mode field positions.
// Pure declarations; no latency or flow control of its own.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS, CMD_BST
    } cmd_t;

    typedef enum logic [1:0] {
        INIT_PRE, INIT_REF, INIT_MRS, READY
    } init_state_t;

    localparam int ERR_NOINIT  = 0;
    localparam int ERR_IDLE    = 1;
    localparam int ERR_ACTOPEN = 2;
    localparam int ERR_TRCD    = 3;
    localparam int ERR_MODE    = 4;
    localparam int ERR_REFOPEN = 5;
    localparam int ERR_BUS     = 6;
    localparam int ERR_REFTMO  = 7;

    localparam int MR_BL_LSB = 0;
    localparam int MR_BL_MSB = 2;
    localparam int MR_CL_LSB = 4;
    localparam int MR_CL_MSB = 6;
    localparam int AP_BIT    = 10;

    function automatic cmd_t decode_cmd(input logic cs_n, input logic ras_n,
                                        input logic cas_n, input logic we_n);
        cmd_t c;
        case ({cs_n, ras_n, cas_n, we_n})
            4'b0011: c = CMD_ACT;
            4'b0101: c = CMD_RD;
            4'b0100: c = CMD_WR;
            4'b0010: c = CMD_PRE;
            4'b0001: c = CMD_REF;
            4'b0000: c = CMD_MRS;
            4'b0110: c = CMD_BST;
            default: c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// One bank's open flag, open row and tRCD down-counter.
// State updates on the edge that samples act_i/close_i; no backpressure.
module sdram_bank_tracker #(
    parameter int ROW_W    = 13,
    parameter int TRCD_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act_i,
    input  logic             close_i,
    input  logic [ROW_W-1:0] row_i,
    output logic             is_open_o,
    output logic [ROW_W-1:0] row_o,
    output logic             rcd_ok_o
);
    localparam int RCD_W = (TRCD_CYC < 1) ? 1 : $clog2(TRCD_CYC + 1);
    localparam logic [RCD_W-1:0] RCD_LOAD = RCD_W'((TRCD_CYC > 0) ? TRCD_CYC - 1 : 0);

    logic             open_q;
    logic [ROW_W-1:0] row_q;
    logic [RCD_W-1:0] rcd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q <= 1'b0;
            row_q  <= '0;
            rcd_q  <= '0;
        end else begin
            if (rcd_q != '0) rcd_q <= rcd_q - 1'b1;
            // The top only raises act_i for an idle bank, so act and close never conflict
            if (act_i) begin
                open_q <= 1'b1;
                row_q  <= row_i;
                rcd_q  <= RCD_LOAD;
            end else if (close_i) begin
                open_q <= 1'b0;
            end
        end
    end

    assign is_open_o = open_q;
    assign row_o     = row_q;
    assign rcd_ok_o  = (rcd_q == '0);

endmodule

// File: rtl/sdram_device_model.sv
// Chip-side SDRAM responder: init FSM, per-bank rows, reduced storage, sticky protocol error flags.
// Read data drives dq for one cycle cas_lat cycles after RD; no backpressure. Refresh watchdog: SDRAM_MODEL_REFRESH_CHECK_EN.
module sdram_device_model
    import sdram_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ROW_W     = 13,
    parameter int COL_W     = 10,
    parameter int ROW_KEEP  = 4,
    parameter int COL_KEEP  = 6,
    parameter int TRCD_CYC  = 1,
    parameter int TREFI_CYC = 1560
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cke,
    input  logic              cs_n,
    input  logic              ras_n,
    input  logic              cas_n,
    input  logic              we_n,
    input  logic [1:0]        ba,
    input  logic [ROW_W-1:0]  addr,
    input  logic              ldqm,
    input  logic              udqm,
    input  logic [DATA_W-1:0] dq_in,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe,
    output logic              initialized,
    output logic [1:0]        cas_lat,
    output logic [7:0]        err_flags
);
    localparam int HALF  = DATA_W / 2;
    localparam int IDX_W = 2 + ROW_KEEP + COL_KEEP;

    cmd_t              cmd;
    init_state_t       state_q, state_d;
    logic              init_ref_q, init_ref_d;
    logic [1:0]        cas_lat_q, cas_lat_d;
    logic [7:0]        err_q, err_d, err_set;
    logic [3:0]        bank_open, bank_rcd_ok, act_vec, close_vec, ap_pend_q, ap_pend_d;
    logic [ROW_W-1:0]  bank_row [4];
    logic [ROW_W-1:0]  sel_row;
    logic              ready, any_open, sel_open, mode_ok, wr_en, rd_push, refi_tmo;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mem [2**IDX_W];
    logic [DATA_W-1:0] rd_dat;
    logic [3:1]        slot_vld_q;
    logic [DATA_W-1:0] slot_dat_q [1:3];
    logic              out_vld_q;
    logic [DATA_W-1:0] out_dat_q;

    for (genvar b = 0; b < 4; b++) begin : g_bank
        sdram_bank_tracker #(.ROW_W(ROW_W), .TRCD_CYC(TRCD_CYC)) u_bank (
            .clk      (clk),
            .rst      (rst),
            .act_i    (act_vec[b]),
            .close_i  (close_vec[b]),
            .row_i    (addr),
            .is_open_o(bank_open[b]),
            .row_o    (bank_row[b]),
            .rcd_ok_o (bank_rcd_ok[b])
        );
    end

    always_comb begin
        cmd        = cke ? decode_cmd(cs_n, ras_n, cas_n, we_n) : CMD_NOP;
        ready      = (state_q == READY);
        any_open   = |bank_open;
        sel_open   = bank_open[ba];
        sel_row    = bank_row[ba];
        idx        = {ba, sel_row[ROW_KEEP-1:0], addr[COL_KEEP-1:0]};
        rd_dat     = mem[idx] & {{HALF{~udqm}}, {HALF{~ldqm}}};
        mode_ok    = (addr[MR_BL_MSB:MR_BL_LSB] == 3'b000) &&
                     ((addr[MR_CL_MSB:MR_CL_LSB] == 3'b010) || (addr[MR_CL_MSB:MR_CL_LSB] == 3'b011));
        state_d    = state_q;
        init_ref_d = init_ref_q;
        cas_lat_d  = cas_lat_q;
        err_set    = '0;
        act_vec    = '0;
        close_vec  = ap_pend_q;  // auto-precharge lands one edge after its RD/WR
        ap_pend_d  = '0;
        wr_en      = 1'b0;
        rd_push    = 1'b0;
        case (cmd)
            CMD_ACT: begin
                if (!ready)        err_set[ERR_NOINIT]  = 1'b1;
                else if (sel_open) err_set[ERR_ACTOPEN] = 1'b1;
                else               act_vec[ba]          = 1'b1;
            end
            CMD_RD, CMD_WR: begin
                if (!ready)         err_set[ERR_NOINIT] = 1'b1;
                else if (!sel_open) err_set[ERR_IDLE]   = 1'b1;
                else begin
                    if (!bank_rcd_ok[ba]) err_set[ERR_TRCD] = 1'b1;
                    if (addr[AP_BIT])     ap_pend_d[ba]     = 1'b1;
                    if (cmd == CMD_WR) begin
                        wr_en = 1'b1;
                        if (out_vld_q) err_set[ERR_BUS] = 1'b1;
                    end else begin
                        rd_push = 1'b1;
                    end
                end
            end
            CMD_PRE: begin
                if (addr[AP_BIT]) close_vec     = '1;
                else              close_vec[ba] = 1'b1;
                if (state_q == INIT_PRE) state_d = INIT_REF;
            end
            CMD_REF: begin
                if (any_open) err_set[ERR_REFOPEN] = 1'b1;
                if (state_q == INIT_REF) begin
                    if (init_ref_q) state_d = INIT_MRS;
                    init_ref_d = 1'b1;
                end
            end
            CMD_MRS: begin
                if (any_open || !mode_ok) err_set[ERR_MODE] = 1'b1;
                else begin
                    cas_lat_d = addr[MR_CL_LSB +: 2];
                    if (state_q == INIT_MRS) state_d = READY;
                end
            end
            default: ;
        endcase
        err_d = err_q | err_set | {refi_tmo, 7'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT_PRE;
            init_ref_q <= 1'b0;
            cas_lat_q  <= 2'd2;
            err_q      <= '0;
            ap_pend_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_ref_q <= init_ref_d;
            cas_lat_q  <= cas_lat_d;
            err_q      <= err_d;
            ap_pend_q  <= ap_pend_d;
        end
    end

    // Storage survives reset so loopback tests can check retention
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!ldqm) mem[idx][HALF-1:0]      <= dq_in[HALF-1:0];
            if (!udqm) mem[idx][DATA_W-1:HALF] <= dq_in[DATA_W-1:HALF];
        end
    end

    // Slot k reaches the output register k edges later, so a read enters at slot cas_lat
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld_q    <= '0;
            slot_dat_q[1] <= '0;
            slot_dat_q[2] <= '0;
            slot_dat_q[3] <= '0;
            out_vld_q     <= 1'b0;
            out_dat_q     <= '0;
        end else begin
            out_vld_q     <= slot_vld_q[1];
            out_dat_q     <= slot_dat_q[1];
            slot_vld_q[1] <= slot_vld_q[2];
            slot_dat_q[1] <= slot_dat_q[2];
            slot_vld_q[2] <= slot_vld_q[3];
            slot_dat_q[2] <= slot_dat_q[3];
            slot_vld_q[3] <= 1'b0;
            slot_dat_q[3] <= '0;
            if (rd_push) begin
                if (cas_lat_q == 2'd3) begin
                    slot_vld_q[3] <= 1'b1;
                    slot_dat_q[3] <= rd_dat;
                end else begin
                    slot_vld_q[2] <= 1'b1;
                    slot_dat_q[2] <= rd_dat;
                end
            end
        end
    end

`ifdef SDRAM_MODEL_REFRESH_CHECK_EN
    localparam int REFI_W = $clog2(TREFI_CYC + 1);
    logic [REFI_W-1:0] refi_q, refi_d;

    always_comb begin
        refi_d   = refi_q;
        refi_tmo = (refi_q == REFI_W'(TREFI_CYC));
        if (cmd == CMD_REF)       refi_d = '0;
        else if (ready && !refi_tmo) refi_d = refi_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) refi_q <= '0;
        else     refi_q <= refi_d;
    end
`else
    assign refi_tmo = 1'b0;
`endif

    assign dq_out      = out_dat_q;
    assign dq_oe       = out_vld_q;
    assign initialized = ready;
    assign cas_lat     = cas_lat_q;
    assign err_flags   = err_q;

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: reads go through a timed scoreboard, status bits through a due-cycle check queue.
module tb_sdram_device_model;

    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;
    localparam int ST_ERR = 0, ST_INIT = 1, ST_CAS = 2, ST_OE = 3;

    typedef struct { logic [15:0] dat; int due; } rd_t;
    typedef struct { int due; int sel; logic [7:0] exp; string name; } st_t;

    logic        clk = 1'b0, rst = 1'b1, cke = 1'b1;
    logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  ba = 2'd0;
    logic [12:0] addr = 13'd0;
    logic        ldqm = 1'b0, udqm = 1'b0;
    logic [15:0] dq_in = 16'd0;
    logic [15:0] dq_out;
    logic        dq_oe, initialized;
    logic [1:0]  cas_lat;
    logic [7:0]  err_flags;

    int  cyc = 0, lat_exp = 2, pass_cnt = 0, total_cnt = 0;
    rd_t rdq[$];
    st_t stq[$];
    rd_t re;

    sdram_device_model #(.TRCD_CYC(2)) dut (
        .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ba(ba), .addr(addr), .ldqm(ldqm), .udqm(udqm), .dq_in(dq_in), .dq_out(dq_out),
        .dq_oe(dq_oe), .initialized(initialized), .cas_lat(cas_lat), .err_flags(err_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [1:0] dqm, input logic [15:0] d);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = b; addr = a; {udqm, ldqm} = dqm; dq_in = d;
        @(posedge clk); #1;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
    endtask

    task automatic nops(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rd(input logic [1:0] b, input logic [12:0] a, input logic [1:0] dqm, input logic [15:0] e);
        issue(C_RD, b, a, dqm, 16'h0);
        rdq.push_back('{dat: e, due: cyc + lat_exp});
    endtask

    task automatic expect_st(input int dly, input int sel, input logic [7:0] e, input string nm);
        stq.push_back('{due: cyc + dly, sel: sel, exp: e, name: nm});
    endtask

    always @(negedge clk) begin
        logic [7:0] got;
        if (dq_oe) begin
            total_cnt++;
            if (rdq.size() == 0) begin
                $display("FAIL rd_unexpected: dq_oe=1 dq_out=%h at cyc %0d, required no read data", dq_out, cyc);
            end else begin
                re = rdq.pop_front();
                if (dq_out === re.dat && cyc == re.due) pass_cnt++;
                else $display("FAIL rd_data: got %h at cyc %0d, required %h at cyc %0d", dq_out, cyc, re.dat, re.due);
            end
        end else if (rdq.size() != 0 && cyc >= rdq[0].due) begin
            re = rdq.pop_front();
            total_cnt++;
            $display("FAIL rd_missing: dq_oe=0 at cyc %0d, required %h", cyc, re.dat);
        end
        for (int i = stq.size() - 1; i >= 0; i--) begin
            if (stq[i].due <= cyc) begin
                case (stq[i].sel)
                    ST_ERR:  got = err_flags;
                    ST_INIT: got = {7'b0, initialized};
                    ST_CAS:  got = {6'b0, cas_lat};
                    default: got = {7'b0, dq_oe};
                endcase
                total_cnt++;
                if (got === stq[i].exp) pass_cnt++;
                else $display("FAIL %s: got %h, required %h at cyc %0d", stq[i].name, got, stq[i].exp, cyc);
                stq.delete(i);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk); #1;
        expect_st(0, ST_ERR,  8'h00, "reset_err");
        expect_st(0, ST_INIT, 8'h00, "reset_init");
        expect_st(0, ST_CAS,  8'h02, "reset_cas");
        expect_st(0, ST_OE,   8'h00, "reset_oe");
        rst = 1'b0;
        cs_n = 1'b1;

        issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        issue(C_REF, 2'd0, 13'h000, 2'b00, 16'h0);
        issue(C_REF, 2'd0, 13'h000, 2'b00, 16'h0);
        expect_st(0, ST_INIT, 8'h00, "init_before_mrs");
        issue(C_MRS, 2'd0, 13'h228, 2'b00, 16'h0);
        expect_st(0, ST_INIT, 8'h01, "init_after_mrs");
        expect_st(0, ST_CAS,  8'h02, "init_cas");
        expect_st(0, ST_ERR,  8'h00, "init_err");

        // Basic write/read, then byte masking on write and on read
        issue(C_ACT, 2'd1, 13'h0055, 2'b00, 16'h0);
        nops(1);
        issue(C_WR, 2'd1, 13'h012, 2'b00, 16'hBEEF);
        rd(2'd1, 13'h012, 2'b00, 16'hBEEF);
        issue(C_WR, 2'd1, 13'h012, 2'b10, 16'h1234);
        rd(2'd1, 13'h012, 2'b00, 16'hBE34);
        rd(2'd1, 13'h012, 2'b01, 16'hBE00);
        nops(3);

        // Idle-bank read, then a tRCD-violating read that still returns data
        issue(C_RD, 2'd2, 13'h005, 2'b00, 16'h0);
        expect_st(0, ST_ERR, 8'h02, "rd_idle_err");
        expect_st(2, ST_OE,  8'h00, "rd_idle_no_data");
        issue(C_ACT, 2'd2, 13'h0003, 2'b00, 16'h0);
        nops(1);
        issue(C_WR, 2'd2, 13'h005, 2'b00, 16'hCAFE);
        issue(C_PRE, 2'd2, 13'h000, 2'b00, 16'h0);
        issue(C_ACT, 2'd2, 13'h0003, 2'b00, 16'h0);
        rd(2'd2, 13'h005, 2'b00, 16'hCAFE);
        expect_st(0, ST_ERR, 8'h0A, "trcd_err");
        nops(2);

        // CAS latency 3, rejected mode, bus contention
        issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        issue(C_MRS, 2'd0, 13'h238, 2'b00, 16'h0);
        lat_exp = 3;
        expect_st(0, ST_CAS, 8'h03, "mrs_cl3");
        issue(C_MRS, 2'd0, 13'h22A, 2'b00, 16'h0);
        expect_st(0, ST_CAS, 8'h03, "bad_mrs_cas");
        expect_st(0, ST_ERR, 8'h1A, "bad_mrs_err");
        issue(C_ACT, 2'd1, 13'h0055, 2'b00, 16'h0);
        nops(1);
        rd(2'd1, 13'h012, 2'b00, 16'hBE34);
        nops(3);
        issue(C_WR, 2'd1, 13'h013, 2'b00, 16'h5555);
        expect_st(0, ST_ERR, 8'h5A, "bus_contention_err");
        nops(1);
        rd(2'd1, 13'h013, 2'b00, 16'h5555);
        nops(4);

        // Reset with a read in flight: flushed, storage retained
        issue(C_RD, 2'd1, 13'h012, 2'b00, 16'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        expect_st(0, ST_OE,   8'h00, "rst_flush_oe");
        expect_st(0, ST_ERR,  8'h00, "rst_err_clear");
        expect_st(0, ST_INIT, 8'h00, "rst_init_clear");
        expect_st(0, ST_CAS,  8'h02, "rst_cas_default");
        expect_st(2, ST_OE,   8'h00, "rst_no_late_data");
        rst = 1'b0;
        lat_exp = 2;
        issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0);
        issue(C_REF, 2'd0, 13'h000, 2'b00, 16'h0);
        issue(C_REF, 2'd0, 13'h000, 2'b00, 16'h0);
        issue(C_MRS, 2'd0, 13'h228, 2'b00, 16'h0);
        expect_st(0, ST_INIT, 8'h01, "reinit_done");

        // ACT to open bank keeps old row; auto-precharge closes the bank
        issue(C_ACT, 2'd1, 13'h0055, 2'b00, 16'h0);
        issue(C_ACT, 2'd1, 13'h0066, 2'b00, 16'h0);
        expect_st(0, ST_ERR, 8'h04, "act_open_err");
        rd(2'd1, 13'h412, 2'b00, 16'hBE34);
        nops(1);
        issue(C_RD, 2'd1, 13'h012, 2'b00, 16'h0);
        expect_st(0, ST_ERR, 8'h06, "rd_after_ap_err");
        expect_st(2, ST_OE,  8'h00, "rd_after_ap_no_data");
        nops(6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
